// File: rtl/ship_collision_ctrl.sv
// Ship collision arbiter: per-frame overlap counting, hit decision at start of frame,
// ship life-cycle FSM. Optional macro SHIP_INVULN_BLINK_EN blinks the ship while invulnerable.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ALIVE     | ship in play, overlaps evaluated at each start_of_frame
// EXPLODING | hit taken, ship hidden for EXPLODE_FRAMES frames
// INVULN    | ship shown (or blinking), cannot be hit for INVULN_FRAMES frames
// GAME_OVER | no lives left, waiting for new_game

module ship_collision_ctrl #(
   parameter int unsigned LIVES          = 3,
   parameter int unsigned MIN_OVERLAP    = 2,
   parameter int unsigned EXPLODE_FRAMES = 60,
   parameter int unsigned INVULN_FRAMES  = 120
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start_of_frame,
   input  logic       ship_draw,
   input  logic       hazard_draw,
   input  logic       new_game,
   output logic       collision,
   output logic       ship_visible,
   output logic [3:0] lives,
   output logic       game_over,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      ALIVE     = 2'd0,
      EXPLODING = 2'd1,
      INVULN    = 2'd2,
      GAME_OVER = 2'd3
   } state_t;

   localparam logic [7:0] MIN_OVL_C  = 8'(MIN_OVERLAP);
   localparam logic [7:0] EXPL_LAST  = 8'(EXPLODE_FRAMES - 1);
   localparam logic [7:0] INVL_LAST  = 8'(INVULN_FRAMES - 1);
   localparam logic [3:0] LIVES_C    = 4'(LIVES);

   state_t     state_q, state_d;
   logic [3:0] lives_q, lives_d;
   logic [7:0] ovl_cnt_q, ovl_cnt_d;
   logic [7:0] frm_cnt_q, frm_cnt_d;
   logic       collision_q, collision_d;
   logic       ship_visible_q, ship_visible_d;
   logic       game_over_q, game_over_d;

   logic       overlap;
   logic       hit;

   assign overlap = ship_draw & hazard_draw;
   assign hit     = start_of_frame && (state_q == ALIVE) && (ovl_cnt_q >= MIN_OVL_C);

   // The start_of_frame pixel belongs to the new frame, so it seeds the counter.
   always_comb begin
      ovl_cnt_d = ovl_cnt_q;
      if (start_of_frame) begin
         ovl_cnt_d = overlap ? 8'd1 : 8'd0;
      end else if (overlap && (ovl_cnt_q != 8'hFF)) begin
         ovl_cnt_d = ovl_cnt_q + 8'd1;
      end
   end

   always_comb begin
      state_d     = state_q;
      lives_d     = lives_q;
      collision_d = 1'b0;
      case (state_q)
         ALIVE: begin
            if (hit) begin
               collision_d = 1'b1;
               if (lives_q > 4'd1) begin
                  lives_d = lives_q - 4'd1;
                  state_d = EXPLODING;
               end else begin
                  lives_d = 4'd0;
                  state_d = GAME_OVER;
               end
            end
         end
         EXPLODING: begin
            if (start_of_frame && (frm_cnt_q == EXPL_LAST)) begin
               state_d = INVULN;
            end
         end
         INVULN: begin
            if (start_of_frame && (frm_cnt_q == INVL_LAST)) begin
               state_d = ALIVE;
            end
         end
         GAME_OVER: begin
            if (new_game) begin
               lives_d = LIVES_C;
               state_d = INVULN;
            end
         end
         default: state_d = INVULN;
      endcase
   end

   always_comb begin
      frm_cnt_d = frm_cnt_q;
      if (state_d != state_q) begin
         frm_cnt_d = 8'd0;
      end else if (start_of_frame && ((state_q == EXPLODING) || (state_q == INVULN))) begin
         frm_cnt_d = frm_cnt_q + 8'd1;
      end
   end

   // Visibility is registered from next-state values so it changes with state.
   always_comb begin
      ship_visible_d = 1'b0;
      game_over_d    = (state_d == GAME_OVER);
      case (state_d)
         ALIVE:   ship_visible_d = 1'b1;
`ifdef SHIP_INVULN_BLINK_EN
         INVULN:  ship_visible_d = ~frm_cnt_d[2];
`else
         INVULN:  ship_visible_d = 1'b1;
`endif
         default: ship_visible_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= INVULN;
         lives_q        <= LIVES_C;
         ovl_cnt_q      <= 8'd0;
         frm_cnt_q      <= 8'd0;
         collision_q    <= 1'b0;
         ship_visible_q <= 1'b1;
         game_over_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         lives_q        <= lives_d;
         ovl_cnt_q      <= ovl_cnt_d;
         frm_cnt_q      <= frm_cnt_d;
         collision_q    <= collision_d;
         ship_visible_q <= ship_visible_d;
         game_over_q    <= game_over_d;
      end
   end

   assign collision    = collision_q;
   assign ship_visible = ship_visible_q;
   assign lives        = lives_q;
   assign game_over    = game_over_q;
   assign state        = state_q;

endmodule

// File: tb/tb_ship_collision_ctrl.sv
// Bench for ship_collision_ctrl: frame-level behavioural model checked every cycle,
// plus directed literal checks for each scenario of interest.

module tb_ship_collision_ctrl;

   localparam int LIVES          = 3;
   localparam int MIN_OVERLAP    = 2;
   localparam int EXPLODE_FRAMES = 60;
   localparam int INVULN_FRAMES  = 120;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start_of_frame = 1'b0;
   logic       ship_draw = 1'b0;
   logic       hazard_draw = 1'b0;
   logic       new_game = 1'b0;
   logic       collision;
   logic       ship_visible;
   logic [3:0] lives;
   logic       game_over;
   logic [1:0] state;

   int n_checks = 0;
   int n_errors = 0;

   ship_collision_ctrl #(
      .LIVES(LIVES), .MIN_OVERLAP(MIN_OVERLAP),
      .EXPLODE_FRAMES(EXPLODE_FRAMES), .INVULN_FRAMES(INVULN_FRAMES)
   ) dut (
      .clk(clk), .reset(reset), .start_of_frame(start_of_frame),
      .ship_draw(ship_draw), .hazard_draw(hazard_draw), .new_game(new_game),
      .collision(collision), .ship_visible(ship_visible), .lives(lives),
      .game_over(game_over), .state(state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic blink_vis(input int frames_in_invuln);
`ifdef SHIP_INVULN_BLINK_EN
      return ((frames_in_invuln / 4) % 2) == 0;
`else
      return (frames_in_invuln >= 0);
`endif
   endfunction

   // Model: states by name as spec numbers, time in INVULN/EXPLODING as frames remaining.
   int   m_state, m_lives, m_ovl, m_left;
   logic e_coll, e_vis, e_go;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_state = 2; m_lives = LIVES; m_ovl = 0; m_left = INVULN_FRAMES;
         e_coll = 0; e_vis = 1; e_go = 0;
      end else begin
         int  prev, old;
         bit  ov;
         prev   = m_state;
         ov     = ship_draw && hazard_draw;
         e_coll = 0;
         old    = m_ovl;
         if (start_of_frame) m_ovl = ov ? 1 : 0;
         else if (ov && m_ovl < 255) m_ovl = m_ovl + 1;
         if (start_of_frame) begin
            if (prev == 0 && old >= MIN_OVERLAP) begin
               e_coll = 1;
               if (m_lives > 1) begin
                  m_lives = m_lives - 1; m_state = 1; m_left = EXPLODE_FRAMES;
               end else begin
                  m_lives = 0; m_state = 3;
               end
            end else if (prev == 1 || prev == 2) begin
               m_left = m_left - 1;
               if (m_left == 0) begin
                  m_state = (prev == 1) ? 2 : 0;
                  m_left  = (prev == 1) ? INVULN_FRAMES : 0;
               end
            end
         end
         if (prev == 3 && new_game) begin
            m_lives = LIVES; m_state = 2; m_left = INVULN_FRAMES;
         end
         e_go  = (m_state == 3);
         e_vis = (m_state == 0) ? 1'b1 :
                 (m_state == 2) ? blink_vis(INVULN_FRAMES - m_left) : 1'b0;
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         chk("model collision", {7'd0, collision}, {7'd0, e_coll});
         chk("model ship_visible", {7'd0, ship_visible}, {7'd0, e_vis});
         chk("model lives", {4'd0, lives}, 8'(m_lives));
         chk("model game_over", {7'd0, game_over}, {7'd0, e_go});
         chk("model state", {6'd0, state}, 8'(m_state));
      end
   end

   task automatic pix(input logic s, input logic sd, input logic hd, input logic ng);
      start_of_frame = s; ship_draw = sd; hazard_draw = hd; new_game = ng;
      @(posedge clk); #1;
      start_of_frame = 0; ship_draw = 0; hazard_draw = 0; new_game = 0;
   endtask

   // 8-cycle frame: sof pixel, then 7 pixels; the first n of them overlap.
   // Non-overlapping pixels still draw the ship alone so only the AND counts.
   task automatic frame(input int n, input logic sof_ov);
      pix(1, sof_ov, sof_ov, 0);
      for (int i = 1; i < 8; i++) pix(0, 1'b1, i <= n, 0);
   endtask

   task automatic idle_rest(input int k);
      for (int i = 0; i < k; i++) pix(0, 0, 1'b1, 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #3;
      chk("reset state", {6'd0, state}, 8'd2);
      chk("reset lives", {4'd0, lives}, 8'd3);
      chk("reset visible", {7'd0, ship_visible}, 8'd1);
      chk("reset collision", {7'd0, collision}, 8'd0);
      reset = 0;
      @(posedge clk); #1;

      // 1: INVULN -> ALIVE on the 120th start_of_frame
      for (int k = 0; k < 119; k++) frame(0, 0);
      chk("t1 still invuln", {6'd0, state}, 8'd2);
      pix(1, 0, 0, 0);
      chk("t1 alive", {6'd0, state}, 8'd0);
      chk("t1 lives", {4'd0, lives}, 8'd3);
      idle_rest(7);

      // 2: one overlap is below threshold, two is a hit
      frame(1, 0);
      pix(1, 0, 0, 0);
      chk("t2 no hit at 1", {7'd0, collision}, 8'd0);
      for (int i = 1; i < 8; i++) pix(0, 1'b1, i <= 2, 0);
      pix(1, 0, 0, 0);
      chk("t2 collision", {7'd0, collision}, 8'd1);
      chk("t2 lives", {4'd0, lives}, 8'd2);
      chk("t2 state", {6'd0, state}, 8'd1);
      chk("t2 visible", {7'd0, ship_visible}, 8'd0);
      pix(0, 0, 0, 0);
      chk("t2 pulse width", {7'd0, collision}, 8'd0);
      idle_rest(6);

      // 5: heavy overlap during EXPLODING and INVULN is ignored
      for (int k = 1; k < EXPLODE_FRAMES; k++) frame(7, 1);
      chk("t5 exploding", {6'd0, state}, 8'd1);
      for (int k = 0; k < INVULN_FRAMES; k++) frame(7, 1);
      chk("t5 invuln", {6'd0, state}, 8'd2);
      chk("t5 lives kept", {4'd0, lives}, 8'd2);
      pix(1, 0, 0, 0);
      chk("t5 alive", {6'd0, state}, 8'd0);
      pix(0, 0, 0, 1);
      pix(0, 0, 0, 1);
      chk("t5 new_game ignored", {6'd0, state}, 8'd0);
      idle_rest(5);
      frame(0, 0);

      // 3: overlap on the start_of_frame pixel counts toward the new frame
      frame(1, 1);
      chk("t3 no hit at boundary", {7'd0, collision}, 8'd0);
      pix(1, 0, 0, 0);
      chk("t3 collision", {7'd0, collision}, 8'd1);
      chk("t3 lives", {4'd0, lives}, 8'd1);
      idle_rest(7);
      for (int k = 1; k < EXPLODE_FRAMES + INVULN_FRAMES; k++) frame(0, 0);
      pix(1, 0, 0, 0);
      chk("t3 alive again", {6'd0, state}, 8'd0);
      idle_rest(7);

      // 4: last life
      frame(2, 0);
      pix(1, 0, 0, 0);
      chk("t4 collision", {7'd0, collision}, 8'd1);
      chk("t4 lives", {4'd0, lives}, 8'd0);
      chk("t4 game_over", {7'd0, game_over}, 8'd1);
      chk("t4 state", {6'd0, state}, 8'd3);
      idle_rest(7);
      for (int k = 0; k < 3; k++) frame(7, 1);
      chk("t4 still over", {6'd0, state}, 8'd3);
      pix(1, 1, 1, 1);
      chk("t4 restart state", {6'd0, state}, 8'd2);
      chk("t4 restart lives", {4'd0, lives}, 8'd3);
      chk("t4 restart game_over", {7'd0, game_over}, 8'd0);

      // 6: blink across INVULN frames, then reset during frame 5
      chk("t6 vis f0", {7'd0, ship_visible}, {7'd0, blink_vis(0)});
      idle_rest(7);
      for (int f = 1; f <= 5; f++) begin
         frame(0, 0);
         chk("t6 vis", {7'd0, ship_visible}, {7'd0, blink_vis(f)});
      end
      #3 reset = 1;
      #1;
      chk("t6 reset state", {6'd0, state}, 8'd2);
      chk("t6 reset lives", {4'd0, lives}, 8'd3);
      chk("t6 reset visible", {7'd0, ship_visible}, 8'd1);
      chk("t6 reset collision", {7'd0, collision}, 8'd0);
      @(posedge clk); #2 reset = 0;
      @(posedge clk); #1;
      for (int f = 0; f < 8; f++) begin
         if (f > 0) frame(0, 0);
         chk("t6 vis after reset", {7'd0, ship_visible}, {7'd0, blink_vis(f)});
      end
      chk("t6 state after reset", {6'd0, state}, 8'd2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
